rf_wb_arbiter: RTL
==================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of writeback requesters sharing the register-file write port.
REQ-002 Parameter XLEN, default 32, data width.
REQ-003 Parameter AW, default 5, register address width (32 registers).
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_req_valid  input  NREQ  per-requester write request.
REQ-007 i_req_addr  input  NREQ x AW  per-requester destination register.
REQ-008 i_req_data  input  NREQ x XLEN  per-requester write data.
REQ-009 o_req_ready  output  NREQ  per-requester accept; at most one bit set.
REQ-010 i_rf_hold  input  1  freezes arbitration (port reserved externally, e.g. debug).
REQ-011 o_we / o_waddr / o_wdata  output  1 / AW / XLEN  registered register-file write port.
REQ-012 i_raddr1, i_raddr2  input  AW each  register-file read addresses for bypass lookup.
REQ-013 o_byp_hit1, o_byp_hit2  output  1 each  in-flight write matches read address.
REQ-014 o_byp_data1, o_byp_data2  output  XLEN each  bypass data.
REQ-015 o_init_done  output  1  high once the clear sweep has completed.

Function
REQ-016 FSM states INIT and RUN; the block SHALL enter INIT on reset.
REQ-017 INIT: each clock SHALL register o_we=1, o_waddr=cnt, o_wdata=0, then cnt+1; cnt starts at 0.
REQ-018 The edge that registers o_waddr=31 SHALL also move state to RUN and set o_init_done=1; no further INIT writes.
REQ-019 In INIT, o_req_ready SHALL be all-zero regardless of i_req_valid.
REQ-020 RUN with i_rf_hold=0: o_req_ready SHALL be combinational, one-hot to the first valid requester found scanning from pointer ptr upward, modulo NREQ.
REQ-021 Transfer = i_req_valid[k] & o_req_ready[k]; on the next edge o_waddr=addr[k], o_wdata=data[k], o_we=(addr[k]!=0).
REQ-022 Writes to register 0 SHALL be accepted (ready asserted) but produce o_we=0.
REQ-023 After a transfer from requester k, ptr SHALL become (k+1) mod NREQ; with no transfer ptr holds.
REQ-024 No transfer in a cycle (none valid, or hold) SHALL register o_we=0; o_waddr/o_wdata hold.
REQ-025 i_rf_hold=1 SHALL force o_req_ready to zero that same cycle; ptr holds.
REQ-026 Latency: exactly one clock from transfer to o_we; sustained throughput one write per clock.
REQ-027 Requesters SHALL hold valid, addr, data stable until ready; the block SHALL NOT depend on valid deasserting after transfer.
REQ-028 o_byp_hitN = o_we & (o_waddr==i_raddrN) & (i_raddrN!=0), combinational; o_byp_dataN = o_wdata.
REQ-029 Bypass SHALL be suppressed (hit=0) while in INIT.

Reset
REQ-030 rst_n low SHALL immediately set state=INIT, cnt=0, ptr=0, o_we=0, o_waddr=0, o_wdata=0, o_init_done=0.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL abandon any pending write and restart the sweep from register 0 after release.
REQ-032 First INIT write SHALL register on the first clock edge after rst_n releases.

Structure
REQ-033 Package rf_pkg SHALL hold XLEN, REG_AW, NREG=32 and the INIT/RUN state enum typedef.
REQ-034 Sub-module rr_arbiter (request vector + pointer -> one-hot grant, combinational) SHALL implement REQ-020.

Verification
REQ-035 Release reset -> 32 consecutive o_we=1 cycles, o_waddr 0..31, o_wdata 0; o_init_done rises with waddr 31; ready 0 throughout.
REQ-036 RUN, all 3 valid, addrs 5/6/7, data A/B/C -> grants 0,1,2,0 over 4 cycles; o_waddr 5,6,7,5 one cycle later.
REQ-037 Req1 valid addr 0 data 0xDEAD -> ready[1]=1, next cycle o_we=0.
REQ-038 Req0 writes reg 9=0x1234, i_raddr1=9, i_raddr2=0 -> next cycle o_byp_hit1=1, data 0x1234, o_byp_hit2=0.
REQ-039 i_rf_hold=1 for 3 cycles with req2 valid -> ready 0, o_we 0; hold drops -> req2 granted same cycle.
REQ-040 Reset pulsed at sweep cnt=17 -> sweep restarts at waddr 0, o_init_done stays 0 until waddr 31.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and state type for the register-file writeback arbiter.
package rf_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 32;

    // INIT sweeps zeros into every register after reset; RUN arbitrates writebacks.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or
// above ptr, wrapping around to index 0 when nothing above ptr is requesting.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    // Two priority passes: wrapped requesters (below ptr) first, then the
    // requesters at or above ptr overwrite them, so the lowest index >= ptr wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k] && (k < int'(ptr))) begin
                grant    = '0;
                grant[k] = 1'b1;
            end
        end
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k] && (k >= int'(ptr))) begin
                grant    = '0;
                grant[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: after reset it clears all registers one per
// clock, then shares the single write port among NREQ requesters round-robin.
// The write port is registered; a bypass view of the in-flight write is exported.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = rf_pkg::XLEN,
    parameter int AW   = rf_pkg::REG_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    i_req_valid,
    input  logic [NREQ*AW-1:0] i_req_addr,
    input  logic [NREQ*XLEN-1:0] i_req_data,
    output logic [NREQ-1:0]    o_req_ready,
    input  logic               i_rf_hold,
    output logic               o_we,
    output logic [AW-1:0]      o_waddr,
    output logic [XLEN-1:0]    o_wdata,
    input  logic [AW-1:0]      i_raddr1,
    input  logic [AW-1:0]      i_raddr2,
    output logic               o_byp_hit1,
    output logic               o_byp_hit2,
    output logic [XLEN-1:0]    o_byp_data1,
    output logic [XLEN-1:0]    o_byp_data2,
    output logic               o_init_done
);

    localparam int          PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

    rf_state_e       state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            we_d, init_done_d;
    logic [AW-1:0]   waddr_d;
    logic [XLEN-1:0] wdata_d;

    logic [NREQ-1:0] grant;
    logic            xfer;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_data;
    logic [PW-1:0]   sel_next_ptr;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .req   (i_req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // Grants only reach requesters in RUN and while the port is not held externally.
    assign o_req_ready = ((state_q == RUN) && !i_rf_hold) ? grant : '0;
    assign xfer        = |(i_req_valid & o_req_ready);

    // Select the winning requester's payload and the pointer value just past it.
    always_comb begin
        sel_addr     = '0;
        sel_data     = '0;
        sel_next_ptr = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (o_req_ready[k]) begin
                sel_addr     = i_req_addr[k*AW +: AW];
                sel_data     = i_req_data[k*XLEN +: XLEN];
                sel_next_ptr = (k == NREQ - 1) ? '0 : PW'(k + 1);
            end
        end
    end

    // Next-state and next-output logic: clear sweep in INIT, arbitrated write in RUN.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        we_d        = 1'b0;
        waddr_d     = o_waddr;
        wdata_d     = o_wdata;
        init_done_d = o_init_done;
        case (state_q)
            INIT: begin
                we_d    = 1'b1;
                waddr_d = cnt_q;
                wdata_d = '0;
                cnt_d   = cnt_q + AW'(1);
                if (cnt_q == LAST_REG) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                if (xfer) begin
                    // Register 0 is hardwired: accept the request but drop the write.
                    we_d    = |sel_addr;
                    waddr_d = sel_addr;
                    wdata_d = sel_data;
                    ptr_d   = sel_next_ptr;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State, sweep counter, pointer and the registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            ptr_q       <= '0;
            o_we        <= 1'b0;
            o_waddr     <= '0;
            o_wdata     <= '0;
            o_init_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            o_we        <= we_d;
            o_waddr     <= waddr_d;
            o_wdata     <= wdata_d;
            o_init_done <= init_done_d;
        end
    end

    // Bypass: the in-flight write matches a non-zero read address; never during the sweep.
    assign o_byp_hit1  = (state_q == RUN) && o_we && (o_waddr == i_raddr1) && (|i_raddr1);
    assign o_byp_hit2  = (state_q == RUN) && o_we && (o_waddr == i_raddr2) && (|i_raddr2);
    assign o_byp_data1 = o_wdata;
    assign o_byp_data2 = o_wdata;

endmodule
